// File: rtl/keyboard_common.sv
// Shared PS/2 keyboard constants, LED bundle type and LED-controller state encoding.
package keyboard_common;

    localparam logic [7:0] KBD_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] KBD_RSP_ACK      = 8'hFA;
    localparam logic [7:0] KBD_RSP_RESEND   = 8'hFE;
    localparam logic [7:0] KBD_RSP_BAT_OK   = 8'hAA;

    typedef struct packed {
        logic caps;
        logic num;
        logic scroll;
    } kbd_leds_t;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_SEND_CMD     = 3'd1,
        ST_WAIT_CMD_ACK = 3'd2,
        ST_SEND_ARG     = 3'd3,
        ST_WAIT_ARG_ACK = 3'd4
    } kbd_state_t;

endpackage

// File: rtl/ps2_kbd_led_ctrl.sv
// PS/2 keyboard LED sequencer: sends ED + LED byte, handles ACK/RESEND/timeout retries
// and forwards all non-response bytes to the scan-code path.
//
// state           | meaning
// ST_IDLE         | no transaction; start one when a request is pending
// ST_SEND_CMD     | offering 8'hED to the transmitter
// ST_WAIT_CMD_ACK | waiting for FA/FE (or timeout) after ED
// ST_SEND_ARG     | offering the LED byte to the transmitter
// ST_WAIT_ARG_ACK | waiting for FA/FE (or timeout) after the LED byte
module ps2_kbd_led_ctrl
    import keyboard_common::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] leds_i,
    input  logic       leds_valid_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic [7:0] scan_data_o,
    output logic       scan_valid_o,
    output logic       busy_o,
    output logic       error_o
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);
    // Timer is loaded with N-1 and expires on the cycle it reads zero, i.e. N cycles in WAIT.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    kbd_state_t       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [RTY_W-1:0] rty_q, rty_d;
    logic             pending_q;
    kbd_leds_t        pend_leds_q;
    kbd_leds_t        led_q;
    logic             error_q, error_d;
    logic [7:0]       scan_data_q;
    logic             scan_valid_q;
    logic             take_req;

    logic wait_st, rx_ack, rx_rsd, rx_bat, rx_consume, tx_fire;

    assign wait_st    = (state_q == ST_WAIT_CMD_ACK) || (state_q == ST_WAIT_ARG_ACK);
    assign rx_ack     = rx_valid_i && (rx_data_i == KBD_RSP_ACK);
    assign rx_rsd     = rx_valid_i && (rx_data_i == KBD_RSP_RESEND);
    assign rx_bat     = rx_valid_i && (rx_data_i == KBD_RSP_BAT_OK);
    assign rx_consume = wait_st && (rx_ack || rx_rsd);
    assign tx_fire    = tx_valid_o && tx_ready_i;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        rty_d    = rty_q;
        error_d  = 1'b0;
        take_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d  = ST_SEND_CMD;
                    take_req = 1'b1;
                    rty_d    = '0;
                end
            end
            ST_SEND_CMD: begin
                if (tx_fire) begin
                    state_d = ST_WAIT_CMD_ACK;
                    tmr_d   = TMR_LOAD;
                end
            end
            ST_SEND_ARG: begin
                if (tx_fire) begin
                    state_d = ST_WAIT_ARG_ACK;
                    tmr_d   = TMR_LOAD;
                end
            end
            ST_WAIT_CMD_ACK, ST_WAIT_ARG_ACK: begin
                if (rx_ack) begin
                    state_d = (state_q == ST_WAIT_CMD_ACK) ? ST_SEND_ARG : ST_IDLE;
                    rty_d   = '0;
                end else if (rx_rsd || (tmr_q == '0)) begin
                    if (rty_q == RTY_MAX) begin
                        state_d = ST_IDLE;
                        error_d = 1'b1;
                        rty_d   = '0;
                    end else begin
                        state_d = (state_q == ST_WAIT_CMD_ACK) ? ST_SEND_CMD : ST_SEND_ARG;
                        rty_d   = rty_q + RTY_W'(1);
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            rty_q        <= '0;
            pending_q    <= 1'b0;
            pend_leds_q  <= '0;
            led_q        <= '0;
            error_q      <= 1'b0;
            scan_data_q  <= 8'h00;
            scan_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rty_q   <= rty_d;
            error_q <= error_d;

            if (take_req) begin
                led_q <= pend_leds_q;
            end

            // A host request beats a same-cycle BAT; BAT only replays the latched LEDs
            // when no newer request is already queued.
            if (leds_valid_i) begin
                pending_q   <= 1'b1;
                pend_leds_q <= kbd_leds_t'(leds_i);
            end else if (rx_bat) begin
                pending_q <= 1'b1;
                if (!pending_q) begin
                    pend_leds_q <= led_q;
                end
            end else if (take_req) begin
                pending_q <= 1'b0;
            end

            scan_valid_q <= rx_valid_i && !rx_consume;
            if (rx_valid_i && !rx_consume) begin
                scan_data_q <= rx_data_i;
            end
        end
    end

    always_comb begin
        case (state_q)
            ST_SEND_CMD: tx_data_o = KBD_CMD_SET_LEDS;
            ST_SEND_ARG: tx_data_o = {5'b00000, led_q};
            default:     tx_data_o = 8'h00;
        endcase
    end

    assign tx_valid_o   = (state_q == ST_SEND_CMD) || (state_q == ST_SEND_ARG);
    assign busy_o       = (state_q != ST_IDLE);
    assign error_o      = error_q;
    assign scan_data_o  = scan_data_q;
    assign scan_valid_o = scan_valid_q;

endmodule

// File: tb/tb_ps2_kbd_led_ctrl.sv
// Scoreboard bench for ps2_kbd_led_ctrl: directed keyboard exchanges, expected tx/scan
// bytes queued by the stimulus and checked by an independent negedge monitor.
module tb_ps2_kbd_led_ctrl;

    localparam int TMO    = 100;
    localparam int HS_MAX = 400;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [2:0] leds_i;
    logic       leds_valid_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic [7:0] scan_data_o;
    logic       scan_valid_o;
    logic       busy_o;
    logic       error_o;

    int         total    = 0;
    int         bad      = 0;
    int         err_seen = 0;
    logic       mon_en   = 1'b0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_scan[$];

    ps2_kbd_led_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_RETRIES(3)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .leds_i      (leds_i),
        .leds_valid_i(leds_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .scan_data_o (scan_data_o),
        .scan_valid_o(scan_valid_o),
        .busy_o      (busy_o),
        .error_o     (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (tx_valid_o && tx_ready_i) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", 32'(tx_data_o) + 32'h100, 32'h0);
                else chk("tx_byte", 32'(tx_data_o), 32'(exp_tx.pop_front()));
            end
            if (scan_valid_o) begin
                if (exp_scan.size() == 0) chk("scan_unexpected", 32'(scan_data_o) + 32'h100, 32'h0);
                else chk("scan_byte", 32'(scan_data_o), 32'(exp_scan.pop_front()));
            end
            if (error_o) err_seen++;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic set_leds(input logic [2:0] v);
        leds_i       = v;
        leds_valid_i = 1'b1;
        tick();
        leds_valid_i = 1'b0;
    endtask

    // Returns the number of idle negedges seen before the handshake.
    task automatic wait_hs(output int cyc);
        logic got;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < HS_MAX) begin
            @(negedge clk_i);
            if (tx_valid_o && tx_ready_i) got = 1'b1;
            else cyc++;
        end
        chk("hs_seen", 32'(got), 32'd1);
        tick();
    endtask

    task automatic push_tx(input logic [7:0] b);
        exp_tx.push_back(b);
    endtask

    initial begin
        int cyc;
        int err0;
        int cnt;

        rst_i        = 1'b1;
        leds_i       = 3'b000;
        leds_valid_i = 1'b0;
        rx_data_i    = 8'h00;
        rx_valid_i   = 1'b0;
        tx_ready_i   = 1'b1;
        repeat (3) tick();
        @(negedge clk_i);
        chk("rst_tx_valid", 32'(tx_valid_o), 0);
        chk("rst_tx_data", 32'(tx_data_o), 0);
        chk("rst_scan_valid", 32'(scan_valid_o), 0);
        chk("rst_scan_data", 32'(scan_data_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_error", 32'(error_o), 0);
        @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        mon_en = 1'b1;
        repeat (3) tick();
        chk("idle_no_busy", 32'(busy_o), 0);

        // Basic ED, 05 with ACKs; busy drops the cycle after the second FA.
        push_tx(8'hED); push_tx(8'h05);
        set_leds(3'b101);
        wait_hs(cyc);
        rx_byte(8'hFA);
        wait_hs(cyc);
        @(negedge clk_i);
        chk("busy_wait_arg", 32'(busy_o), 1);
        tick();
        rx_byte(8'hFA);
        @(negedge clk_i);
        chk("busy_after_fa", 32'(busy_o), 0);
        tick();

        // RESEND on ED, plus tx_data held while transmitter stalls.
        err0 = err_seen;
        push_tx(8'hED); push_tx(8'hED); push_tx(8'h03);
        set_leds(3'b011);
        wait_hs(cyc);
        rx_byte(8'hFE);
        wait_hs(cyc);
        tx_ready_i = 1'b0;
        rx_byte(8'hFA);
        repeat (3) begin
            @(negedge clk_i);
            chk("stall_valid", 32'(tx_valid_o), 1);
            chk("stall_data", 32'(tx_data_o), 32'h03);
        end
        @(posedge clk_i);
        #1;
        tx_ready_i = 1'b1;
        wait_hs(cyc);
        rx_byte(8'hFA);
        repeat (2) tick();
        chk("resend_no_error", 32'(err_seen), 32'(err0));

        // Silent keyboard: ED four times at exact timeout spacing, then one error pulse.
        err0 = err_seen;
        repeat (4) push_tx(8'hED);
        set_leds(3'b111);
        wait_hs(cyc);
        repeat (3) begin
            wait_hs(cyc);
            chk("retry_gap", 32'(cyc), 32'(TMO));
        end
        cnt = 0;
        while (busy_o && cnt < 300) begin
            @(negedge clk_i);
            cnt++;
        end
        chk("abort_cycles", 32'(cnt), 32'(TMO + 1));
        repeat (5) tick();
        chk("abort_idle", 32'(busy_o), 0);
        chk("abort_error_once", 32'(err_seen), 32'(err0 + 1));

        // Scan forwarding: 1C forwarded during WAIT, ACKs consumed, FA in IDLE forwarded.
        push_tx(8'hED); push_tx(8'h02);
        set_leds(3'b010);
        wait_hs(cyc);
        exp_scan.push_back(8'h1C);
        rx_byte(8'h1C);
        rx_byte(8'hFA);
        wait_hs(cyc);
        rx_byte(8'hFA);
        tick();
        exp_scan.push_back(8'hFA);
        rx_byte(8'hFA);
        repeat (3) tick();
        chk("scan_drained", 32'(exp_scan.size()), 0);
        chk("idle_fa_no_tx", 32'(busy_o), 0);

        // Newest request wins while busy; BAT replays last LEDs.
        push_tx(8'hED); push_tx(8'h06); push_tx(8'hED); push_tx(8'h04);
        set_leds(3'b110);
        wait_hs(cyc);
        set_leds(3'b001);
        set_leds(3'b100);
        rx_byte(8'hFA);
        wait_hs(cyc);
        rx_byte(8'hFA);
        wait_hs(cyc);
        rx_byte(8'hFA);
        wait_hs(cyc);
        rx_byte(8'hFA);
        repeat (2) tick();
        exp_scan.push_back(8'hAA);
        push_tx(8'hED); push_tx(8'h04);
        rx_byte(8'hAA);
        wait_hs(cyc);
        rx_byte(8'hFA);
        wait_hs(cyc);
        rx_byte(8'hFA);
        repeat (2) tick();

        // Host request and BAT in the same cycle: host LEDs win.
        exp_scan.push_back(8'hAA);
        push_tx(8'hED); push_tx(8'h03);
        rx_data_i    = 8'hAA;
        rx_valid_i   = 1'b1;
        leds_i       = 3'b011;
        leds_valid_i = 1'b1;
        tick();
        rx_valid_i   = 1'b0;
        leds_valid_i = 1'b0;
        wait_hs(cyc);
        rx_byte(8'hFA);
        wait_hs(cyc);
        rx_byte(8'hFA);
        repeat (2) tick();

        // Reset during WAIT_ARG_ACK with a queued request: everything dropped, no error.
        err0 = err_seen;
        push_tx(8'hED); push_tx(8'h05);
        set_leds(3'b101);
        wait_hs(cyc);
        rx_byte(8'hFA);
        wait_hs(cyc);
        set_leds(3'b111);
        rst_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk("mid_rst_tx_valid", 32'(tx_valid_o), 0);
        chk("mid_rst_tx_data", 32'(tx_data_o), 0);
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_scan_valid", 32'(scan_valid_o), 0);
        chk("mid_rst_scan_data", 32'(scan_data_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cnt = 0;
        repeat (3 * TMO) begin
            @(negedge clk_i);
            if (tx_valid_o || busy_o) cnt++;
        end
        chk("post_rst_quiet", 32'(cnt), 0);
        chk("post_rst_no_error", 32'(err_seen), 32'(err0));

        chk("tx_queue_empty", 32'(exp_tx.size()), 0);
        chk("scan_queue_empty", 32'(exp_scan.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
